int_alu_issue: RTL and testbench

//   Issue/collect front end for the combinational integer ALU (int_alu).

---
 rtl/int_alu_pkg.sv | 31 +++
 rtl/alu_req_fifo.sv | 70 +++++++
 rtl/int_alu_issue.sv | 138 +++++++++++++
 tb/tb_int_alu_issue.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/int_alu_pkg.sv
// Shared types and constants for the integer ALU and its issue front end.
package int_alu_pkg;

    localparam int unsigned ALU_XLEN = 64;
    localparam int unsigned ALU_OPC_W = 5;

    typedef enum logic [2:0] {
        ALU_ADD     = 3'd0,
        ALU_SUB     = 3'd1,
        ALU_AND     = 3'd2,
        ALU_OR      = 3'd3,
        ALU_XOR     = 3'd4,
        ALU_SLL     = 3'd5,
        ALU_SRL     = 3'd6,
        ALU_ILLEGAL = 3'd7
    } alu_op_e;

    typedef struct packed {
        logic [ALU_XLEN-1:0]  op_a;
        logic [ALU_XLEN-1:0]  op_b;
        logic [ALU_OPC_W-1:0] opcode;
    } alu_req_t;

    localparam int unsigned ALU_REQ_W = $bits(alu_req_t);

    // Reserved upper opcode bits or the unimplemented op encoding make a request illegal.
    function automatic logic opcode_illegal(input logic [ALU_OPC_W-1:0] opc);
        return (opc[2:0] == 3'(ALU_ILLEGAL)) || (opc[4:3] != 2'b00);
    endfunction

endpackage

// File: rtl/alu_req_fifo.sv
// In-order synchronous FIFO holding pending ALU requests; head is visible combinationally.
module alu_req_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           wdata_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           rdata_c,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       full_c,
    output logic                       empty_c
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty_c = (wr_ptr_q == rd_ptr_q);
    assign full_c  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                     (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);

    assign do_push = push_i && !full_c;
    assign do_pop  = pop_i && !empty_c;

    assign rdata_c = mem_q[rd_ptr_q[PTR_W-1:0]];
    assign count_o = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + (PTR_W+1)'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + (PTR_W+1)'(1);
        end
        count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage needs no reset: entries are only read once the pointers say they are valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[PTR_W-1:0]] <= wdata_i;
        end
    end

endmodule

// File: rtl/int_alu_issue.sv
// Issue/collect front end for int_alu: request FIFO, ALU drive, and a registered response stage.
module int_alu_issue
    import int_alu_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TAG_W = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [ALU_XLEN-1:0]        req_op_a,
    input  logic [ALU_XLEN-1:0]        req_op_b,
    input  logic [ALU_OPC_W-1:0]       req_opcode,
    input  logic [TAG_W-1:0]           req_tag,
    output logic [ALU_XLEN-1:0]        alu_op_a,
    output logic [ALU_XLEN-1:0]        alu_op_b,
    output logic [ALU_OPC_W-1:0]       alu_opcode,
    input  logic [ALU_XLEN-1:0]        alu_result,
    input  logic                       alu_valid,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [ALU_XLEN-1:0]        rsp_result,
    output logic [TAG_W-1:0]           rsp_tag,
    output logic                       rsp_illegal,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    localparam int unsigned CNT_W = $clog2(DEPTH+1);

    typedef struct packed {
        alu_req_t         req;
        logic [TAG_W-1:0] tag;
    } fifo_entry_t;

    localparam int unsigned ENTRY_W = $bits(fifo_entry_t);

    fifo_entry_t         push_entry;
    fifo_entry_t         head_entry;
    logic [ENTRY_W-1:0]  head_raw;
    logic                fifo_full;
    logic                fifo_empty;
    logic [CNT_W-1:0]    fifo_count;
    logic                push;
    logic                cap;
    logic                head_illegal;
    logic [CNT_W-1:0]    count_nxt;

    logic                req_ready_q, req_ready_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [ALU_XLEN-1:0] rsp_result_q, rsp_result_d;
    logic [TAG_W-1:0]    rsp_tag_q, rsp_tag_d;
    logic                rsp_illegal_q, rsp_illegal_d;

    assign push_entry.req.op_a   = req_op_a;
    assign push_entry.req.op_b   = req_op_b;
    assign push_entry.req.opcode = req_opcode;
    assign push_entry.tag        = req_tag;

    // req_ready is registered, so a push is only ever offered when the FIFO had room.
    assign push = req_valid && req_ready_q;
    assign cap  = !fifo_empty && alu_valid && (!rsp_valid_q || rsp_ready);

    alu_req_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .wdata_i (push_entry),
        .pop_i   (cap),
        .rdata_c (head_raw),
        .count_o (fifo_count),
        .full_c  (fifo_full),
        .empty_c (fifo_empty)
    );

    assign head_entry   = fifo_entry_t'(head_raw);
    assign head_illegal = opcode_illegal(head_entry.req.opcode);

    // ALU sees zeros whenever there is nothing to issue.
    always_comb begin
        alu_op_a   = '0;
        alu_op_b   = '0;
        alu_opcode = '0;
        if (!fifo_empty) begin
            alu_op_a   = head_entry.req.op_a;
            alu_op_b   = head_entry.req.op_b;
            alu_opcode = head_entry.req.opcode;
        end
    end

    // Ready tracks next-cycle occupancy; a pop in the same cycle as full does not open a bypass.
    always_comb begin
        count_nxt   = fifo_count + CNT_W'(push) - CNT_W'(cap);
        req_ready_d = (count_nxt != CNT_W'(DEPTH));
    end

    always_comb begin
        rsp_valid_d   = rsp_valid_q;
        rsp_result_d  = rsp_result_q;
        rsp_tag_d     = rsp_tag_q;
        rsp_illegal_d = rsp_illegal_q;
        if (cap) begin
            rsp_valid_d   = 1'b1;
            rsp_result_d  = head_illegal ? '0 : alu_result;
            rsp_tag_d     = head_entry.tag;
            rsp_illegal_d = head_illegal;
        end else if (rsp_valid_q && rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_ready_q   <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_result_q  <= '0;
            rsp_tag_q     <= '0;
            rsp_illegal_q <= 1'b0;
        end else begin
            req_ready_q   <= req_ready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_result_q  <= rsp_result_d;
            rsp_tag_q     <= rsp_tag_d;
            rsp_illegal_q <= rsp_illegal_d;
        end
    end

    assign req_ready   = req_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_result  = rsp_result_q;
    assign rsp_tag     = rsp_tag_q;
    assign rsp_illegal = rsp_illegal_q;
    assign occupancy   = fifo_count;

endmodule

// File: tb/tb_int_alu_issue.sv
// Scoreboard bench for int_alu_issue with a behavioural ALU model driving alu_result.
module tb_int_alu_issue;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned TAG_W = 4;
    localparam int unsigned CNT_W = $clog2(DEPTH+1);

    typedef struct {
        logic [63:0]      res;
        logic [TAG_W-1:0] tag;
        logic             ill;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [63:0]      req_op_a = '0;
    logic [63:0]      req_op_b = '0;
    logic [4:0]       req_opcode = '0;
    logic [TAG_W-1:0] req_tag = '0;
    logic [63:0]      alu_op_a, alu_op_b, alu_result;
    logic [4:0]       alu_opcode;
    logic             alu_valid = 1'b1;
    logic             rsp_valid;
    logic             rsp_ready = 1'b1;
    logic [63:0]      rsp_result;
    logic [TAG_W-1:0] rsp_tag;
    logic             rsp_illegal;
    logic [CNT_W-1:0] occupancy;

    int n_checks = 0;
    int n_pass = 0;
    int cyc = 0;
    exp_t sb[$];
    int pop_cyc[$];

    int_alu_issue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op_a(req_op_a), .req_op_b(req_op_b), .req_opcode(req_opcode), .req_tag(req_tag),
        .alu_op_a(alu_op_a), .alu_op_b(alu_op_b), .alu_opcode(alu_opcode),
        .alu_result(alu_result), .alu_valid(alu_valid),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_tag(rsp_tag), .rsp_illegal(rsp_illegal), .occupancy(occupancy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural ALU: returns a poison pattern for the unimplemented encoding.
    always_comb begin
        case (alu_opcode[2:0])
            3'd0:    alu_result = alu_op_a + alu_op_b;
            3'd1:    alu_result = alu_op_a - alu_op_b;
            3'd2:    alu_result = alu_op_a & alu_op_b;
            3'd3:    alu_result = alu_op_a | alu_op_b;
            3'd4:    alu_result = alu_op_a ^ alu_op_b;
            3'd5:    alu_result = alu_op_a << alu_op_b[5:0];
            3'd6:    alu_result = alu_op_a >> alu_op_b[5:0];
            default: alu_result = 64'hDEAD_BEEF_DEAD_BEEF;
        endcase
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // Monitor: compares every handshaken response and the hold rule under backpressure.
    logic             hold_prev = 1'b0;
    logic [63:0]      prev_res;
    logic [TAG_W-1:0] prev_tag;
    logic             prev_ill;
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                hold_prev = 1'b0;
            end else begin
                if (hold_prev) begin
                    chk("hold_valid", 64'(rsp_valid), 64'd1);
                    chk("hold_result", rsp_result, prev_res);
                    chk("hold_tag", 64'(rsp_tag), 64'(prev_tag));
                    chk("hold_illegal", 64'(rsp_illegal), 64'(prev_ill));
                end
                if (rsp_valid && rsp_ready) begin
                    pop_cyc.push_back(cyc);
                    if (sb.size() == 0) begin
                        fail_now($sformatf("unexpected_rsp tag=%0d result=%h", rsp_tag, rsp_result));
                    end else begin
                        e = sb.pop_front();
                        chk("rsp_result", rsp_result, e.res);
                        chk("rsp_tag", 64'(rsp_tag), 64'(e.tag));
                        chk("rsp_illegal", 64'(rsp_illegal), 64'(e.ill));
                    end
                end
                hold_prev = rsp_valid && !rsp_ready;
                prev_res  = rsp_result;
                prev_tag  = rsp_tag;
                prev_ill  = rsp_illegal;
            end
        end
    end

    task automatic push(input logic [63:0] a, input logic [63:0] b, input logic [4:0] op,
                        input logic [TAG_W-1:0] tag, input logic [63:0] exp_res, input logic exp_ill);
        exp_t e;
        logic acc;
        int   t;
        e.res = exp_res; e.tag = tag; e.ill = exp_ill;
        sb.push_back(e);
        req_op_a = a; req_op_b = b; req_opcode = op; req_tag = tag; req_valid = 1'b1;
        t = 0;
        do begin
            @(negedge clk);
            acc = req_ready;
            @(posedge clk); #1;
            t++;
        end while (!acc && t < 200);
        if (!acc) fail_now("push_timeout");
        req_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int t = 0;
        while ((sb.size() != 0 || rsp_valid) && t < 300) begin
            @(posedge clk); #1;
            t++;
        end
        if (sb.size() != 0 || rsp_valid) fail_now("drain_timeout");
    endtask

    initial begin
        int base;
        #2;
        // Reset values while held in reset.
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_result", rsp_result, 64'd0);
        chk("rst_rsp_tag", 64'(rsp_tag), 64'd0);
        chk("rst_occupancy", 64'(occupancy), 64'd0);
        chk("rst_alu_op_a", alu_op_a, 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        chk("ready_before_edge", 64'(req_ready), 64'd0);
        @(posedge clk); #1;
        chk("ready_after_release", 64'(req_ready), 64'd1);

        // 1: single ADD with two-edge latency.
        push(64'd5, 64'd7, 5'd0, 4'd3, 64'd12, 1'b0);
        chk("t1_valid_edgeN", 64'(rsp_valid), 64'd0);
        @(posedge clk); #1;
        chk("t1_valid_edgeN1", 64'(rsp_valid), 64'd1);
        wait_drain();

        // 2: back-to-back SUB/AND/SLL, responses on consecutive cycles.
        base = pop_cyc.size();
        push(64'd10, 64'd3, 5'd1, 4'd4, 64'd7, 1'b0);
        push(64'hF0F0, 64'hFF00, 5'd2, 4'd5, 64'hF000, 1'b0);
        push(64'd1, 64'd63, 5'd5, 4'd6, 64'h8000_0000_0000_0000, 1'b0);
        wait_drain();
        if (pop_cyc.size() == base + 3) begin
            chk("t2_consec_1", 64'(pop_cyc[base+1] - pop_cyc[base]), 64'd1);
            chk("t2_consec_2", 64'(pop_cyc[base+2] - pop_cyc[base+1]), 64'd1);
        end else begin
            fail_now("t2_rsp_count");
        end

        // 3: backpressure fills FIFO plus response register.
        rsp_ready = 1'b0;
        push(64'h0F, 64'hF0, 5'd3, 4'd8, 64'hFF, 1'b0);
        push(64'hFF, 64'h0F, 5'd4, 4'd9, 64'hF0, 1'b0);
        push(64'h8000_0000_0000_0000, 64'd4, 5'd6, 4'd10, 64'h0800_0000_0000_0000, 1'b0);
        push(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 5'd0, 4'd11, 64'd0, 1'b0);
        push(64'd0, 64'd1, 5'd1, 4'd12, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        chk("t3_ready_full", 64'(req_ready), 64'd0);
        chk("t3_occupancy", 64'(occupancy), 64'd4);
        chk("t3_rsp_valid", 64'(rsp_valid), 64'd1);
        repeat (3) @(posedge clk);
        #1;
        chk("t3_occ_held", 64'(occupancy), 64'd4);
        chk("t3_ready_held", 64'(req_ready), 64'd0);
        rsp_ready = 1'b1;
        wait_drain();
        chk("t3_occ_empty", 64'(occupancy), 64'd0);

        // 4: illegal opcodes return zero and the flag.
        push(64'd9, 64'd9, 5'd7, 4'd1, 64'd0, 1'b1);
        push(64'd2, 64'd3, 5'b01000, 4'd2, 64'd0, 1'b1);
        wait_drain();

        // 5: stalled ALU holds the FIFO and response register.
        alu_valid = 1'b0;
        push(64'd100, 64'd1, 5'd0, 4'd13, 64'd101, 1'b0);
        push(64'd100, 64'd1, 5'd1, 4'd14, 64'd99, 1'b0);
        push(64'd6, 64'd3, 5'd4, 4'd15, 64'd5, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("t5_occ_%0d", i), 64'(occupancy), 64'd3);
            chk($sformatf("t5_rsp_valid_%0d", i), 64'(rsp_valid), 64'd0);
        end
        @(posedge clk); #1;
        alu_valid = 1'b1;
        wait_drain();

        // 6: reset mid-operation discards queued and captured work.
        rsp_ready = 1'b0;
        push(64'd1, 64'd1, 5'd0, 4'd0, 64'd2, 1'b0);
        push(64'd2, 64'd1, 5'd0, 4'd1, 64'd3, 1'b0);
        push(64'd3, 64'd1, 5'd0, 4'd2, 64'd4, 1'b0);
        push(64'd4, 64'd1, 5'd0, 4'd3, 64'd5, 1'b0);
        chk("t6_pre_occ", 64'(occupancy), 64'd3);
        chk("t6_pre_valid", 64'(rsp_valid), 64'd1);
        rst_n = 1'b0;
        sb.delete();
        #1;
        chk("t6_rst_valid", 64'(rsp_valid), 64'd0);
        chk("t6_rst_occ", 64'(occupancy), 64'd0);
        chk("t6_rst_result", rsp_result, 64'd0);
        chk("t6_rst_tag", 64'(rsp_tag), 64'd0);
        chk("t6_rst_ready", 64'(req_ready), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk("t6_ready_after", 64'(req_ready), 64'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("t6_no_stale_%0d", i), 64'(rsp_valid), 64'd0);
        end
        @(posedge clk); #1;
        push(64'd20, 64'd22, 5'd0, 4'd9, 64'd42, 1'b0);
        wait_drain();

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
